// File: rtl/diff_rx.sv
// diff_rx: pulse-width serial link receiver.
// Decodes SYNC + 26 data bits + trailing SYNC-width low from a single wire,
// classifying each symbol by the width of its low phase.
module diff_rx #(
  parameter int DATA_PERIOD = 20
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        data_in,
  output logic [25:0] data_out,
  output logic        valid_out,
  output logic        error_out,
  output logic [2:0]  state_out
);

  localparam int CW = $clog2(DATA_PERIOD) + 1;

  localparam logic [CW-1:0] MIN_LOW  = CW'(DATA_PERIOD / 8);
  localparam logic [CW-1:0] ZERO_MAX = CW'((3 * DATA_PERIOD) / 8);
  localparam logic [CW-1:0] SYNC_MAX = CW'((5 * DATA_PERIOD) / 8);
  localparam logic [CW-1:0] ONE_MAX  = CW'((7 * DATA_PERIOD) / 8);
  localparam logic [CW-1:0] HIGH_MAX = CW'(DATA_PERIOD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [4:0]    NBITS    = 5'd26;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_LOW  = 3'd1,
    S_HDR_HIGH = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_BIT_HIGH = 3'd4,
    S_RECOVER  = 3'd5
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_low_cnt;
  logic [CW-1:0] r_high_cnt;
  logic [4:0]    r_bit_cnt;
  logic [25:0]   r_shift;
  logic          r_valid_p;
  logic          r_error_p;
  logic [25:0]   r_data;
  logic          r_valid;
  logic          r_error;

  logic          w_line;
  logic [CW-1:0] w_low_inc;
  logic [CW-1:0] w_high_inc;
  logic          w_is_zero;
  logic          w_is_sync;
  logic          w_is_one;
  logic          w_low_over;
  logic          w_high_to;

  state_t        w_state_nx;
  logic [CW-1:0] w_low_nx;
  logic [CW-1:0] w_high_nx;
  logic [4:0]    w_bit_nx;
  logic [25:0]   w_shift_nx;
  logic          w_valid;
  logic          w_error;

  assign w_line     = r_sync2;
  assign w_low_inc  = (r_low_cnt == '1) ? r_low_cnt : r_low_cnt + CNT_ONE;
  assign w_high_inc = (r_high_cnt == '1) ? r_high_cnt : r_high_cnt + CNT_ONE;
  assign w_is_zero  = (r_low_cnt >= MIN_LOW) && (r_low_cnt <= ZERO_MAX);
  assign w_is_sync  = (r_low_cnt > ZERO_MAX) && (r_low_cnt <= SYNC_MAX);
  assign w_is_one   = (r_low_cnt > SYNC_MAX) && (r_low_cnt <= ONE_MAX);
  // r_low_cnt already holds ONE_MAX, so the low cycle seen now is one too many
  assign w_low_over = (r_low_cnt >= ONE_MAX);
  assign w_high_to  = (w_high_inc >= HIGH_MAX);

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter and strobe decisions from the synchronized line
  always_comb begin
    w_state_nx = r_state;
    w_low_nx   = r_low_cnt;
    w_high_nx  = r_high_cnt;
    w_bit_nx   = r_bit_cnt;
    w_shift_nx = r_shift;
    w_valid    = 1'b0;
    w_error    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_line) begin
          w_state_nx = S_HDR_LOW;
          w_low_nx   = CNT_ONE;
          w_high_nx  = '0;
        end
      end
      S_HDR_LOW: begin
        if (!w_line) begin
          if (w_low_over) begin
            w_error    = 1'b1;
            w_state_nx = S_RECOVER;
          end else begin
            w_low_nx = w_low_inc;
          end
        end else if (w_is_sync) begin
          w_state_nx = S_HDR_HIGH;
          w_bit_nx   = '0;
          w_high_nx  = CNT_ONE;
        end else begin
          w_error    = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_HDR_HIGH, S_BIT_HIGH: begin
        if (w_line) begin
          if (w_high_to) begin
            w_error    = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_high_nx = w_high_inc;
          end
        end else begin
          w_state_nx = S_BIT_LOW;
          w_low_nx   = CNT_ONE;
          w_high_nx  = '0;
        end
      end
      S_BIT_LOW: begin
        if (!w_line) begin
          if (w_low_over) begin
            w_error    = 1'b1;
            w_state_nx = S_RECOVER;
          end else begin
            w_low_nx = w_low_inc;
          end
        end else if (r_bit_cnt < NBITS) begin
          if (w_is_zero || w_is_one) begin
            w_shift_nx = {r_shift[24:0], w_is_one};
            w_bit_nx   = r_bit_cnt + 5'd1;
            w_high_nx  = CNT_ONE;
            w_state_nx = S_BIT_HIGH;
          end else begin
            w_error    = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          if (w_is_sync) begin
            w_valid = 1'b1;
          end else begin
            w_error = 1'b1;
          end
          w_state_nx = S_IDLE;
        end
      end
      S_RECOVER: begin
        if (w_line) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // FSM state, counters and shift register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_low_cnt  <= '0;
      r_high_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_valid_p  <= 1'b0;
      r_error_p  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_low_cnt  <= w_low_nx;
      r_high_cnt <= w_high_nx;
      r_bit_cnt  <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_valid_p  <= w_valid;
      r_error_p  <= w_error;
    end
  end

  // Output register stage; r_shift cannot move the cycle after a frame completes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= r_valid_p;
      r_error <= r_error_p;
      if (r_valid_p) begin
        r_data <= r_shift;
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign error_out = r_error;
  assign state_out = r_state;

endmodule
